banked_load_mem: RTL and testbench
==================================

// Module: banked_load_mem
// PURPOSE
//  Parametrised banked on-chip memory for NPU operands (image/conv/dense data) with a built-in stream loader.
//  A host byte stream is scattered round-robin across NUM_BANKS banks: element i goes to bank i%NUM_BANKS, word i/NUM_BANKS.
//  The compute side reads all banks at one shared address; a registered valid tracks the configurable read latency.
//  A direct single-bank write port serves patch-ups outside load sessions. Replaces fixed 4x8-bit instance wiring.
// PARAMETERS
//  NUM_BANKS  4   number of banks; power of two, 1..8
//  DATA_W     8   bits per bank word
//  ADDR_W     10  word address width per bank (depth = 2**ADDR_W)
//  RD_LAT     1   read latency in cycles, 1 or 2 (2 adds output register)
// PORTS
//  clk        in   1                    rising-edge clock
//  reset      in   1                    async, active-low reset
//  ld_start   in   1                    pulse: begin load session, element counter := 0
//  ld_valid   in   1                    ld_data valid
//  ld_ready   out  1                    loader accepts element this cycle
//  ld_data    in   DATA_W               stream element
//  ld_last    in   1                    marks final element of session
//  ld_done    out  1                    session finished (sticky until next ld_start)
//  ld_full    out  1                    session ended by capacity, not ld_last
//  ld_count   out  ADDR_W+log2(NB)+1    elements written in current/last session
//  wr_en      in   1                    direct write strobe
//  wr_bank    in   max(1,log2(NB))      direct write bank
//  wr_addr    in   ADDR_W               direct write word address
//  wr_data    in   DATA_W               direct write data
//  wr_drop    out  1                    pulse: wr_en rejected (load active)
//  rd_en      in   1                    read request
//  rd_addr    in   ADDR_W               shared read address
//  rd_valid   out  1                    rd_data valid
//  rd_data    out  NUM_BANKS*DATA_W     bank b at [b*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, ld_ready=0, ld_done=0, ld_full=0, ld_count=0, wr_drop=0,
//   rd_valid=0, rd_data=0, pipeline regs cleared. RAM contents NOT reset.
//  FSM IDLE -> LOAD on ld_start. LOAD -> DONE on accepted element with ld_last=1, or when
//   ld_count reaches NUM_BANKS*2**ADDR_W (ld_full=1). DONE -> LOAD on ld_start. ld_start in LOAD
//   restarts session (count:=0, done/full:=0); an element in that same cycle is ignored.
//  Handshake: ld_ready=1 only in LOAD. Element accepted when ld_valid&&ld_ready; written same edge
//   to bank ld_count%NB, word ld_count/NB; ld_count increments. No stall on read side.
//  ld_done/ld_full set on the edge the terminating element is accepted; ld_ready drops next cycle.
//  Direct write: honoured in IDLE/DONE, written same edge. In LOAD, wr_en ignored, wr_drop=1 next cycle (1-cycle pulse per wr_en).
//  Read: rd_en sampled at edge N; RD_LAT=1 -> rd_data/rd_valid at N+1; RD_LAT=2 -> at N+2.
//   rd_valid deasserts when no request; rd_data holds last value. Back-to-back reads fully pipelined.
//  Read-during-write same bank/word same edge: old data returned (read-before-write).
//  Mid-session reset: FSM to IDLE, partially loaded RAM retained but ld_count/ld_done cleared.
//  Widths: ld_count never wraps; capacity check prevents address overflow.
// TESTING
//  1 Load 8 bytes 0x10..0x17 (ld_last on 8th), NB=4: read addr0 -> rd_data=0x13121110, addr1 -> 0x17161514, ld_done=1, ld_full=0, ld_count=8.
//  2 ld_valid toggled every other cycle during load: same final contents as test 1; ld_count=8 exactly.
//  3 ADDR_W=2, NB=4: stream 20 bytes without ld_last -> 16 accepted, ld_full=1, ld_ready=0 after 16th, bytes 17..20 not written.
//  4 wr_en during LOAD -> wr_drop pulse, RAM unchanged; wr_en bank2 addr5 data 0xAA in DONE -> read addr5 bank2 byte=0xAA.
//  5 RD_LAT=2: rd_en on 3 consecutive cycles addr0,1,2 -> rd_valid high 3 cycles starting 2 cycles later, data in order; same-edge write to addr1 returns old word.
//  6 Assert reset mid-load after 5 elements -> all outputs at reset values; ld_start restarts with ld_count=0, bank0 word0 overwritten first.

Source files
------------

// File: rtl/banked_load_mem.sv
// banked_load_mem
//   Banked on-chip operand memory with a built-in stream loader.
//   A host byte stream is scattered round-robin over NUM_BANKS banks
//   (element i -> bank i%NUM_BANKS, word i/NUM_BANKS). The compute side
//   reads every bank at one shared address with RD_LAT cycles of latency.
//   A direct single-bank write port is available outside load sessions.
// Ports
//   clk, reset                : rising-edge clock, async active-low reset
//   ld_start                  : pulse, begins/restarts a load session
//   ld_valid/ld_ready/ld_data : stream handshake, ld_last marks final element
//   ld_done, ld_full          : session finished (sticky) / ended by capacity
//   ld_count                  : elements written in current/last session
//   wr_en/wr_bank/wr_addr/wr_data : direct write, wr_drop pulses if rejected
//   rd_en/rd_addr             : shared read request
//   rd_valid/rd_data          : read result, bank b at [b*DATA_W +: DATA_W]
module banked_load_mem #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int RD_LAT    = 1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         ld_start,
   input  logic                                         ld_valid,
   output logic                                         ld_ready,
   input  logic [DATA_W-1:0]                            ld_data,
   input  logic                                         ld_last,
   output logic                                         ld_done,
   output logic                                         ld_full,
   output logic [ADDR_W+$clog2(NUM_BANKS):0]            ld_count,
   input  logic                                         wr_en,
   input  logic [(NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1)-1:0] wr_bank,
   input  logic [ADDR_W-1:0]                            wr_addr,
   input  logic [DATA_W-1:0]                            wr_data,
   output logic                                         wr_drop,
   input  logic                                         rd_en,
   input  logic [ADDR_W-1:0]                            rd_addr,
   output logic                                         rd_valid,
   output logic [NUM_BANKS*DATA_W-1:0]                  rd_data
);

   localparam int LOG2NB = $clog2(NUM_BANKS);
   localparam int BW     = (NUM_BANKS > 1) ? LOG2NB : 1;
   localparam int CW     = ADDR_W + LOG2NB + 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int CAP    = NUM_BANKS * DEPTH;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t                          state, state_nx;
   logic                            load_acc, dir_wr, cap_hit;
   logic [BW-1:0]                   ld_bank;
   logic [ADDR_W-1:0]               ld_word, waddr;
   logic [DATA_W-1:0]               wdata;
   logic [NUM_BANKS-1:0]            bank_we;
   logic [NUM_BANKS-1:0][DATA_W-1:0] rd_q1;
   logic                            rd_v1;

   logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

   // Low count bits pick the bank, the next ADDR_W bits pick the word.
   assign ld_bank = (NUM_BANKS == 1) ? '0 : ld_count[BW-1:0];
   assign ld_word = ld_count[LOG2NB +: ADDR_W];
   assign cap_hit = (ld_count == CW'(CAP - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load_acc = 1'b0;
      dir_wr   = 1'b0;
      ld_ready = 1'b0;
      case (state)
         S_LOAD: begin
            ld_ready = 1'b1;
            // A restart takes priority; an element presented alongside it is dropped.
            if (!ld_start && ld_valid) begin
               load_acc = 1'b1;
               if (ld_last || cap_hit) state_nx = S_DONE;
            end
         end
         default: begin
            dir_wr = wr_en;
            if (ld_start) state_nx = S_LOAD;
         end
      endcase
      waddr = (state == S_LOAD) ? ld_word : wr_addr;
      wdata = (state == S_LOAD) ? ld_data : wr_data;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         bank_we[b] = (load_acc && (ld_bank == BW'(b))) ||
                      (dir_wr && (wr_bank == BW'(b)));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_count <= '0;
         ld_done  <= 1'b0;
         ld_full  <= 1'b0;
         wr_drop  <= 1'b0;
      end else begin
         wr_drop <= wr_en && (state == S_LOAD);
         if (ld_start) begin
            ld_count <= '0;
            ld_done  <= 1'b0;
            ld_full  <= 1'b0;
         end else if (load_acc) begin
            ld_count <= ld_count + 1'b1;
            if (ld_last || cap_hit) begin
               ld_done <= 1'b1;
               ld_full <= cap_hit && !ld_last;
            end
         end
      end
   end

   // RAM array itself is not reset.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (bank_we[b]) mem[b][waddr] <= wdata;
      end
   end

   // First read stage; non-blocking RAM update gives read-before-write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q1 <= '0;
         rd_v1 <= 1'b0;
      end else begin
         rd_v1 <= rd_en;
         if (rd_en) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) rd_q1[b] <= mem[b][rd_addr];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [NUM_BANKS-1:0][DATA_W-1:0] rd_q2;
         logic                             rd_v2;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rd_q2 <= '0;
               rd_v2 <= 1'b0;
            end else begin
               rd_v2 <= rd_v1;
               if (rd_v1) rd_q2 <= rd_q1;
            end
         end
         assign rd_valid = rd_v2;
         assign rd_data  = rd_q2;
      end else begin : g_lat1
         assign rd_valid = rd_v1;
         assign rd_data  = rd_q1;
      end
   endgenerate

endmodule

// File: tb/tb_banked_load_mem.sv
module tb_banked_load_mem;

   localparam int NB = 4;
   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_start, ld_valid, ld_last;
   logic [DW-1:0] ld_data;
   logic          wr_en;
   logic [1:0]    wr_bank;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;

   logic          ld_ready1, ld_done1, ld_full1, wr_drop1, rd_valid1;
   logic [4:0]    ld_count1;
   logic [31:0]   rd_data1;
   logic          ld_ready2, ld_done2, ld_full2, wr_drop2, rd_valid2;
   logic [4:0]    ld_count2;
   logic [31:0]   rd_data2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   banked_load_mem #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_data(ld_data),
      .ld_last(ld_last), .ld_done(ld_done1), .ld_full(ld_full1), .ld_count(ld_count1),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop1),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid1), .rd_data(rd_data1)
   );

   banked_load_mem #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_data(ld_data),
      .ld_last(ld_last), .ld_done(ld_done2), .ld_full(ld_full2), .ld_count(ld_count2),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop2),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid2), .rd_data(rd_data2)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   exp;
   } read_vec_t;

   read_vec_t rv [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("ready_after_start1", ld_ready1, 1);
      chk("ready_after_start2", ld_ready2, 1);
      chk("count_after_start", ld_count1, 0);
   endtask

   task automatic send(input logic [7:0] d, input logic last, input int exp_count);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("count_send1", ld_count1, exp_count);
      chk("count_send2", ld_count2, exp_count);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
      chk("rd_valid1", rd_valid1, 1);
      chk("rd_data1", rd_data1, exp);
      chk("rd_valid2_early", rd_valid2, 0);
      tick();
      chk("rd_valid1_drop", rd_valid1, 0);
      chk("rd_data1_hold", rd_data1, exp);
      chk("rd_valid2", rd_valid2, 1);
      chk("rd_data2", rd_data2, exp);
   endtask

   task automatic read_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) do_read(rv[i].addr, rv[i].exp);
   endtask

   task automatic chk_reset_vals();
      chk("rst_ready1", ld_ready1, 0);   chk("rst_ready2", ld_ready2, 0);
      chk("rst_done1", ld_done1, 0);     chk("rst_done2", ld_done2, 0);
      chk("rst_full1", ld_full1, 0);     chk("rst_full2", ld_full2, 0);
      chk("rst_count1", ld_count1, 0);   chk("rst_count2", ld_count2, 0);
      chk("rst_drop1", wr_drop1, 0);     chk("rst_drop2", wr_drop2, 0);
      chk("rst_rvalid1", rd_valid1, 0);  chk("rst_rvalid2", rd_valid2, 0);
      chk("rst_rdata1", rd_data1, 0);    chk("rst_rdata2", rd_data2, 0);
   endtask

   initial begin
      rv[0]  = '{2'd0, 32'h13121110};
      rv[1]  = '{2'd1, 32'h17161514};
      rv[2]  = '{2'd0, 32'h23222120};
      rv[3]  = '{2'd1, 32'h27262524};
      rv[4]  = '{2'd0, 32'h43424140};
      rv[5]  = '{2'd1, 32'h47464544};
      rv[6]  = '{2'd2, 32'h4B4A4948};
      rv[7]  = '{2'd3, 32'h4F4E4D4C};
      rv[8]  = '{2'd1, 32'h47464544};   // dropped write left RAM unchanged
      rv[9]  = '{2'd1, 32'h47AA4544};   // direct write in DONE landed in bank 2
      rv[10] = '{2'd0, 32'h73727180};   // bank0 rewritten, banks1..3 retained
      rv[11] = '{2'd1, 32'h47AA4574};

      reset = 1'b0; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
      wr_en = 0; wr_bank = '0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
      tick(); tick();
      chk_reset_vals();
      reset = 1'b1;
      tick();

      // Test 1: 8 back-to-back elements, last on the 8th
      start_session();
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7, i + 1);
      chk("t1_done", ld_done1, 1);
      chk("t1_full", ld_full1, 0);
      chk("t1_ready", ld_ready1, 0);
      read_range(0, 2);

      // Test 2: valid on every other cycle
      start_session();
      for (int i = 0; i < 8; i++) begin
         send(8'h20 + 8'(i), i == 7, i + 1);
         if (i != 7) begin
            tick();
            chk("t2_count_idle", ld_count1, i + 1);
         end
      end
      chk("t2_done", ld_done2, 1);
      chk("t2_full", ld_full2, 0);
      read_range(2, 4);

      // Test 3: 20 elements without ld_last, capacity 16
      start_session();
      ld_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ld_data = 8'h40 + 8'(i);
         tick();
         chk("t3_count", ld_count1, (i < 16) ? i + 1 : 16);
         chk("t3_ready", ld_ready1, (i < 15) ? 1 : 0);
         chk("t3_full", ld_full1, (i < 15) ? 0 : 1);
      end
      ld_valid = 1'b0;
      chk("t3_done", ld_done1, 1);
      chk("t3_full2", ld_full2, 1);
      read_range(4, 8);

      // Test 4: direct write dropped in LOAD, honoured in DONE
      start_session();
      wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 2'd1; wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      chk("t4_drop1", wr_drop1, 1);
      chk("t4_drop2", wr_drop2, 1);
      tick();
      chk("t4_drop_pulse", wr_drop1, 0);
      for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), i == 3, i + 1);
      chk("t4_done", ld_done1, 1);
      chk("t4_full", ld_full1, 0);
      read_range(8, 9);
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("t4_nodrop", wr_drop1, 0);
      read_range(9, 10);

      // Test 5: back-to-back reads, same-edge write to addr1 returns old word
      rd_en = 1'b1; rd_addr = 2'd0;
      tick();
      chk("t5_v1_c1", rd_valid1, 1);  chk("t5_d1_c1", rd_data1, 32'h63626160);
      chk("t5_v2_c1", rd_valid2, 0);
      rd_addr = 2'd1; wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 2'd1; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      chk("t5_v1_c2", rd_valid1, 1);  chk("t5_d1_c2", rd_data1, 32'h47AA4544);
      chk("t5_v2_c2", rd_valid2, 1);  chk("t5_d2_c2", rd_data2, 32'h63626160);
      rd_addr = 2'd2;
      tick();
      rd_en = 1'b0;
      chk("t5_d1_c3", rd_data1, 32'h4B4A4948);
      chk("t5_v2_c3", rd_valid2, 1);  chk("t5_d2_c3", rd_data2, 32'h47AA4544);
      tick();
      chk("t5_v1_c4", rd_valid1, 0);  chk("t5_d1_hold", rd_data1, 32'h4B4A4948);
      chk("t5_v2_c4", rd_valid2, 1);  chk("t5_d2_c4", rd_data2, 32'h4B4A4948);
      tick();
      chk("t5_v2_c5", rd_valid2, 0);  chk("t5_d2_hold", rd_data2, 32'h4B4A4948);
      do_read(2'd1, 32'h47AA4555);

      // Test 6: reset after 5 elements, then restart
      start_session();
      for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0, i + 1);
      reset = 1'b0;
      #1;
      chk_reset_vals();
      tick();
      reset = 1'b1;
      tick();
      start_session();
      send(8'h80, 1'b1, 1);
      chk("t6_done", ld_done1, 1);
      read_range(10, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
